// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from a FIFO read port and serialises them as 8N1/8N2 UART frames
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_tx_en                   transmit enable, looked at only while idle
//   i_fifo_empty              FIFO empty flag
//   o_fifo_rd_en              one-cycle FIFO pop strobe per frame
//   i_fifo_rd_data/_valid     FIFO read data, valid one cycle after the pop
//   o_tx                      serial line, idle high
//   o_busy                    high while a frame is in progress
//   o_done                    one-cycle pulse in the first idle cycle after a frame
module uart_fifo_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tx_en,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_rd_en,
    input  logic [DATA_BITS-1:0] i_fifo_rd_data,
    input  logic                 i_fifo_rd_valid,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP} state_t;
    state_t               r_state;
    logic [TW-1:0]        r_tmr;
    logic [BW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_rd_en, r_tx, r_busy, r_done;
    logic                 w_tick;
    logic [DATA_BITS-1:0] w_next;
    assign w_tick = r_tmr == T_LAST;
    assign w_next = r_shift >> 1;
    assign o_fifo_rd_en = r_rd_en;
    assign o_tx = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;
    // Outputs are assigned on the transition into the state they belong to,
    // so they stay registered and line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_tmr   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_rd_en <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            if (r_state == START || r_state == DATA || r_state == STOP)
                r_tmr <= w_tick ? '0 : r_tmr + 1'b1;
            case (r_state)
                IDLE: if (i_tx_en && !i_fifo_empty) begin
                    r_state <= FETCH;
                    r_rd_en <= 1'b1;
                    r_busy  <= 1'b1;
                end
                FETCH: r_state <= WAIT;
                WAIT: if (i_fifo_rd_valid) begin
                    r_shift <= i_fifo_rd_data;
                    r_tmr   <= '0;
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: if (w_tick) begin
                    r_state <= DATA;
                    r_idx   <= '0;
                    r_tx    <= r_shift[0];
                end
                DATA: if (w_tick) begin
                    if (r_idx == D_LAST) begin
                        r_state <= STOP;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                    end else begin
                        r_shift <= w_next;
                        r_tx    <= w_next[0];
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                // r_idx is reused to count stop bits
                STOP: if (w_tick) begin
                    if (r_idx == S_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
